dma_copy: RTL and testbench

DMA_COPY -- requirements
Module: dma_copy

---
 rtl/dma_copy_pkg.sv | 35 +++
 rtl/dma_copy.sv | 202 ++++++++++++++++++++
 tb/tb_dma_copy.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_copy_pkg.sv
// -----------------------------------------------------------------------------
// dma_copy_pkg
// Shared definitions for the word-copy DMA engine:
//   - address/data widths of the memory port
//   - WORD_MASK : access-size code driven on sign_mask (32-bit word, unsigned)
//   - ADDR_INC  : byte stride between consecutive words
//   - state_e   : controller state encoding
//   - next_word_addr() : stride helper, wraps modulo 2^ADDR_W
// -----------------------------------------------------------------------------
package dma_copy_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  localparam logic [3:0]        WORD_MASK = 4'b0100;
  localparam logic [ADDR_W-1:0] ADDR_INC  = 12'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT_HI,
    ST_RD_WAIT_LO,
    ST_WR_REQ,
    ST_WR_WAIT_HI,
    ST_WR_WAIT_LO,
    ST_FINISH
  } state_e;

  // Address arithmetic is ADDR_W bits wide, so the carry out of the top bit
  // is simply dropped: running past 0xFFC lands on 0x000.
  function automatic logic [ADDR_W-1:0] next_word_addr(input logic [ADDR_W-1:0] a);
    return a + ADDR_INC;
  endfunction

endpackage

// File: rtl/dma_copy.sv
// -----------------------------------------------------------------------------
// dma_copy
// Copies len 32-bit words from src_addr to dst_addr over a single shared
// load/store port with a stall-based handshake. Each word is one read
// (strobe, wait for clk_stall high, wait for clk_stall low, capture data)
// followed by one write with the same handshake.
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   start                one-cycle copy request, only looked at in IDLE
//   src_addr, dst_addr   word-aligned byte addresses of first source/dest word
//   len                  number of words; 0 completes immediately
//   busy                 high while a copy is in progress
//   done / error         one-cycle completion / handshake-timeout pulses
//   addr, write_data     memory address and store data
//   memread, memwrite    one-cycle load / store strobes
//   sign_mask            access size, always a word
//   read_data            load result, sampled when clk_stall falls
//   clk_stall            responder busy flag
//
// Parameters
//   TIMEOUT  cycles allowed, counted from the request strobe, for clk_stall
//            to rise (must be >= 2)
//   LEN_W    width of len
// -----------------------------------------------------------------------------
module dma_copy
  import dma_copy_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int LEN_W   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] write_data,
  output logic              memwrite,
  output logic              memread,
  output logic [3:0]        sign_mask,
  input  logic [DATA_W-1:0] read_data,
  input  logic              clk_stall
);

  localparam int               TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  state_e              state_q;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                last_word;
  logic [TMR_W-1:0]    tmr_q;
  logic                busy_q, done_q, error_q;
  logic                memread_q, memwrite_q;
  logic [ADDR_W-1:0]   addr_q;
  // Doubles as the holding register for the word in flight.
  logic [DATA_W-1:0]   wdata_q;

  // Per-word pointer/count updates, applied when a write handshake finishes.
  always_comb begin
    src_d     = next_word_addr(src_q);
    dst_d     = next_word_addr(dst_q);
    cnt_d     = cnt_q - LEN_ONE;
    last_word = (cnt_q == LEN_ONE);
  end

  // The timer is cleared when a request strobe is launched and counts the
  // strobe cycle plus every WAIT_HI cycle, so error fires TIMEOUT cycles after
  // the strobe if clk_stall never rises.
  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; blocking = would let later branches see
  // half-updated state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      cnt_q      <= '0;
      tmr_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      // NOTE: pulses and strobes default low every cycle and are only raised
      // on the transition into the state that owns them, which makes them
      // exactly one cycle wide without any per-state clearing.
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (len != '0) begin
              src_q     <= src_addr;
              dst_q     <= dst_addr;
              cnt_q     <= len;
              addr_q    <= src_addr;
              memread_q <= 1'b1;
              tmr_q     <= '0;
              state_q   <= ST_RD_REQ;
            end else begin
              state_q <= ST_FINISH;
            end
          end
        end

        ST_RD_REQ: begin
          tmr_q   <= tmr_q + TMR_ONE;
          state_q <= ST_RD_WAIT_HI;
        end

        ST_RD_WAIT_HI: begin
          if (clk_stall) begin
            state_q <= ST_RD_WAIT_LO;
          end else if (tmr_q >= TMR_LAST) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            tmr_q <= tmr_q + TMR_ONE;
          end
        end

        ST_RD_WAIT_LO: begin
          if (!clk_stall) begin
            wdata_q    <= read_data;
            addr_q     <= dst_q;
            memwrite_q <= 1'b1;
            tmr_q      <= '0;
            state_q    <= ST_WR_REQ;
          end
        end

        ST_WR_REQ: begin
          tmr_q   <= tmr_q + TMR_ONE;
          state_q <= ST_WR_WAIT_HI;
        end

        ST_WR_WAIT_HI: begin
          if (clk_stall) begin
            state_q <= ST_WR_WAIT_LO;
          end else if (tmr_q >= TMR_LAST) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            tmr_q <= tmr_q + TMR_ONE;
          end
        end

        ST_WR_WAIT_LO: begin
          if (!clk_stall) begin
            src_q <= src_d;
            dst_q <= dst_d;
            cnt_q <= cnt_d;
            if (last_word) begin
              state_q <= ST_FINISH;
            end else begin
              addr_q    <= src_d;
              memread_q <= 1'b1;
              tmr_q     <= '0;
              state_q   <= ST_RD_REQ;
            end
          end
        end

        ST_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign addr       = addr_q;
  assign write_data = wdata_q;
  assign memread    = memread_q;
  assign memwrite   = memwrite_q;
  assign sign_mask  = WORD_MASK;

endmodule

// File: tb/tb_dma_copy.sv
// -----------------------------------------------------------------------------
// tb_dma_copy
// Drives copy jobs into dma_copy against a behavioural stall-handshake memory.
// Expected read addresses, write address/data pairs and completion events are
// pushed into queues when a job is issued; a separate monitor pops and compares
// whenever the DUT strobes memread/memwrite or pulses done/error.
// -----------------------------------------------------------------------------
module tb_dma_copy;

  localparam int TIMEOUT   = 15;
  localparam int LEN_W     = 8;
  localparam int MEM_WORDS = 1024;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [11:0]       src_addr = '0;
  logic [11:0]       dst_addr = '0;
  logic [LEN_W-1:0]  len = '0;
  logic              busy, done, error;
  logic [11:0]       addr;
  logic [31:0]       write_data;
  logic              memwrite, memread;
  logic [3:0]        sign_mask;
  logic [31:0]       read_data = '0;
  logic              clk_stall = 1'b0;

  dma_copy #(.TIMEOUT(TIMEOUT), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .addr       (addr),
    .write_data (write_data),
    .memwrite   (memwrite),
    .memread    (memread),
    .sign_mask  (sign_mask),
    .read_data  (read_data),
    .clk_stall  (clk_stall)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc_now = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int last_rd_cyc = 0;
  bit resp_dead = 1'b0;
  bit resp_rand = 1'b0;

  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;
  typedef enum bit {EV_DONE, EV_ERR} ev_e;

  logic [11:0] exp_rd_q[$];
  wr_t         exp_wr_q[$];
  ev_e         exp_ev_q[$];

  always @(posedge clk) cyc_now <= cyc_now + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a sequential word-by-word copy over a scratch image of
  // memory, so overlapping source/destination ranges read back earlier writes.
  task automatic model_copy(input logic [11:0] s, input logic [11:0] d, input int n);
    logic [31:0] work [MEM_WORDS];
    logic [11:0] sa, da;
    wr_t w;
    work = ref_mem;
    for (int i = 0; i < n; i++) begin
      sa = s + 12'(4 * i);
      da = d + 12'(4 * i);
      exp_rd_q.push_back(sa);
      w.addr = da;
      w.data = work[sa[11:2]];
      work[da[11:2]] = w.data;
      exp_wr_q.push_back(w);
    end
    exp_ev_q.push_back(EV_DONE);
  endtask

  // Memory responder: stall rises after the edge following the strobe (plus
  // an optional random delay), holds for 2 cycles (or 1..3 when randomised),
  // and load data becomes valid when stall falls.
  initial begin : responder
    logic [11:0] a;
    logic [31:0] rd;
    bit          is_wr;
    int          dly, hold;
    forever begin
      @(negedge clk);
      if ((memread || memwrite) && !resp_dead) begin
        a     = addr;
        is_wr = memwrite;
        rd    = mem[a[11:2]];
        if (is_wr) mem[a[11:2]] = write_data;
        dly  = resp_rand ? $urandom_range(0, 2) : 0;
        hold = resp_rand ? $urandom_range(1, 3) : 2;
        @(posedge clk);
        repeat (dly) @(posedge clk);
        #1 clk_stall = 1'b1;
        read_data = $urandom;
        repeat (hold) @(posedge clk);
        #1 clk_stall = 1'b0;
        if (!is_wr) read_data = rd;
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (memread && memwrite) begin
      n_vec++;
      n_err++;
      $display("FAIL strobe_overlap: memread=1 memwrite=1, expected at most one high");
    end
    if (memread || memwrite) begin
      check("busy_during_strobe", busy, 1);
      check("sign_mask", sign_mask, 4'b0100);
    end
    if (memread) begin
      rd_cnt++;
      last_rd_cyc = cyc_now;
      if (exp_rd_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_read: addr 0x%0h, expected no read", addr);
      end else begin
        check("rd_addr", addr, exp_rd_q.pop_front());
      end
    end
    if (memwrite) begin
      wr_cnt++;
      if (exp_wr_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", addr, write_data);
      end else begin
        wr_t w;
        w = exp_wr_q.pop_front();
        check("wr_addr", addr, w.addr);
        check("wr_data", write_data, w.data);
        ref_mem[w.addr[11:2]] = w.data;
      end
    end
    if (done || error) begin
      check("busy_low_at_pulse", busy, 0);
      if (done && error) begin
        n_vec++;
        n_err++;
        $display("FAIL done_and_error: both high, expected one");
      end else if (exp_ev_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_completion: done=%0b error=%0b, expected none", done, error);
      end else begin
        ev_e ev;
        ev = error ? EV_ERR : EV_DONE;
        check("completion_kind", ev, exp_ev_q.pop_front());
      end
    end
  end

  task automatic run_copy(input logic [11:0] s, input logic [11:0] d, input int n,
                          input bit mid, output int done_cyc);
    int rd0, wr0, cyc, busy_cycles;
    bit got;
    model_copy(s, d, n);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    cyc = 0;
    busy_cycles = 0;
    got = 1'b0;
    done_cyc = 0;
    src_addr = s;
    dst_addr = d;
    len = LEN_W'(n);
    start = 1'b1;
    while (!got && cyc < 2000) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (busy) busy_cycles++;
      if (done || error) begin
        got = 1'b1;
        done_cyc = cyc;
        check("copy_ended_with_done", done, 1);
      end else if (mid && cyc == 5) begin
        start = 1'b1;
        src_addr = 12'h800;
        dst_addr = 12'hA00;
        len = LEN_W'(7);
      end
    end
    check("copy_completed", got, 1);
    check("busy_span", busy_cycles, done_cyc - 1);
    check("read_strobes", rd_cnt - rd0, n);
    check("write_strobes", wr_cnt - wr0, n);
    repeat (2) @(negedge clk);
  endtask

  initial begin : main
    int dc, cyc, rd0, wr0, pulses, bad;
    bit got;
    logic [11:0] s, d;

    for (int i = 0; i < MEM_WORDS; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_memread", memread, 0);
    check("rst_memwrite", memwrite, 0);
    check("rst_addr", addr, 0);
    check("rst_write_data", write_data, 0);
    check("rst_sign_mask", sign_mask, 4'b0100);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // A,B,C copy with a fixed 2-cycle-stall responder.
    resp_rand = 1'b0;
    mem[0] = 32'hAAAA_0001; ref_mem[0] = 32'hAAAA_0001;
    mem[1] = 32'hBBBB_0002; ref_mem[1] = 32'hBBBB_0002;
    mem[2] = 32'hCCCC_0003; ref_mem[2] = 32'hCCCC_0003;
    run_copy(12'h000, 12'h100, 3, 1'b0, dc);
    check("abc_word0", mem[12'h100 >> 2], 32'hAAAA_0001);
    check("abc_word1", mem[12'h104 >> 2], 32'hBBBB_0002);
    check("abc_word2", mem[12'h108 >> 2], 32'hCCCC_0003);
    check("throughput_8_per_word", dc <= 8 * 3 + 2, 1);

    // Zero-length request.
    run_copy(12'h040, 12'h300, 0, 1'b0, dc);
    check("len0_done_cycle", dc, 2);

    // Source wraps past the top of the address space.
    run_copy(12'hFFC, 12'h200, 2, 1'b0, dc);

    // Second start while busy must be ignored.
    run_copy(12'h010, 12'h400, 4, 1'b1, dc);

    // Handshake timeout: responder never raises clk_stall.
    resp_dead = 1'b1;
    exp_rd_q.push_back(12'h080);
    exp_ev_q.push_back(EV_ERR);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    src_addr = 12'h080;
    dst_addr = 12'h700;
    len = LEN_W'(1);
    start = 1'b1;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (done || error) begin
        got = 1'b1;
        check("timeout_error_pulse", error, 1);
        check("timeout_latency", cyc_now - last_rd_cyc, TIMEOUT);
      end
    end
    check("timeout_seen", got, 1);
    check("timeout_reads", rd_cnt - rd0, 1);
    check("timeout_writes", wr_cnt - wr0, 0);
    @(negedge clk);
    check("timeout_idle_busy", busy, 0);
    resp_dead = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during WR_WAIT_HI of word 2 of 4.
    model_copy(12'h0C0, 12'h500, 4);
    wr0 = wr_cnt;
    src_addr = 12'h0C0;
    dst_addr = 12'h500;
    len = LEN_W'(4);
    start = 1'b1;
    cyc = 0;
    while ((wr_cnt - wr0) < 2 && cyc < 200) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    check("reached_word2_write", wr_cnt - wr0, 2);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_error", error, 0);
    check("arst_memread", memread, 0);
    check("arst_memwrite", memwrite, 0);
    check("arst_addr", addr, 0);
    check("arst_write_data", write_data, 0);
    check("arst_sign_mask", sign_mask, 4'b0100);
    exp_rd_q.delete();
    exp_wr_q.delete();
    exp_ev_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || error || busy) pulses++;
    end
    check("no_activity_after_abort", pulses, 0);

    // Normal operation after the aborted transfer.
    run_copy(12'h020, 12'h600, 3, 1'b0, dc);

    // Randomised jobs against a randomised responder.
    resp_rand = 1'b1;
    for (int k = 0; k < 12; k++) begin
      s = 12'($urandom) & 12'hFFC;
      d = 12'($urandom) & 12'hFFC;
      run_copy(s, d, $urandom_range(0, 6), ($urandom_range(0, 3) == 0), dc);
    end

    check("rd_queue_drained", exp_rd_q.size(), 0);
    check("wr_queue_drained", exp_wr_q.size(), 0);
    check("ev_queue_drained", exp_ev_q.size(), 0);
    bad = 0;
    for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("memory_image", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
